// File: rtl/stream_demux_1_4.sv
// stream_demux_1_4 -- 1-to-4 packet demultiplexer for valid/ready streams.
//
// Each packet is steered to one of four destinations. The destination is taken
// from in_sel on the packet's first beat and locked until the last beat is
// accepted. A single registered output slot gives 1-cycle latency. Accepting a
// new beat while the held one drains in the same cycle keeps full throughput.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   in_valid/in_ready   upstream handshake (in_ready is combinational from out_ready)
//   in_data/in_last     upstream beat payload and end-of-packet flag
//   in_sel              destination 0..3, sampled on a packet's first beat only
//   out_valid[3:0]      one-hot (or zero) beat-pending flag per destination
//   out_ready[3:0]      per-destination ready
//   out_data/out_last   held beat payload/last, shared by all destinations
//   busy                a packet is open (first beat accepted, last not yet)
//   cur_dest            destination locked for the current or most recent packet
module stream_demux_1_4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic [1:0]       in_sel,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy,
    output logic [1:0]       cur_dest
);

    typedef enum logic {S_IDLE, S_BUSY} state_e;

    state_e           state_q, state_d;
    logic             ov_q, ov_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             last_q, last_d;
    logic [1:0]       dest_q, dest_d;
    logic [1:0]       cur_dest_q, cur_dest_d;

    logic             accept;
    logic             drain;
    logic [1:0]       beat_dest;

    // The slot frees up when its own destination takes the beat, so a new
    // beat can be loaded in the same cycle. in_valid is deliberately absent.
    assign drain    = ov_q & out_ready[dest_q];
    assign in_ready = ~ov_q | out_ready[dest_q];
    assign accept   = in_valid & in_ready;

    // First beat of a packet routes by in_sel; later beats follow the lock.
    assign beat_dest = (state_q == S_IDLE) ? in_sel : cur_dest_q;

    always_comb begin
        state_d    = state_q;
        ov_d       = ov_q;
        data_d     = data_q;
        last_d     = last_q;
        dest_d     = dest_q;
        cur_dest_d = cur_dest_q;
        if (accept) begin
            ov_d       = 1'b1;
            data_d     = in_data;
            last_d     = in_last;
            dest_d     = beat_dest;
            cur_dest_d = beat_dest;
            state_d    = in_last ? S_IDLE : S_BUSY;
        end else if (drain) begin
            ov_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ov_q       <= 1'b0;
            data_q     <= '0;
            last_q     <= 1'b0;
            dest_q     <= 2'd0;
            cur_dest_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            ov_q       <= ov_d;
            data_q     <= data_d;
            last_q     <= last_d;
            dest_q     <= dest_d;
            cur_dest_q <= cur_dest_d;
        end
    end

    // One valid bit per destination; at most one can be set since the slot
    // carries a single dest.
    for (genvar k = 0; k < 4; k++) begin : g_lane
        assign out_valid[k] = ov_q & (dest_q == 2'(k));
    end

    assign out_data = data_q;
    assign out_last = last_q;
    assign busy     = (state_q == S_BUSY);
    assign cur_dest = cur_dest_q;

endmodule

// File: tb/tb_stream_demux_1_4.sv
// Self-checking bench for stream_demux_1_4. A queue of accepted-but-undelivered
// beats stands in for the output slot; routing follows the packet-lock rules.
module tb_stream_demux_1_4;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic [1:0]       in_sel;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             busy;
    logic [1:0]       cur_dest;

    stream_demux_1_4 #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .cur_dest  (cur_dest)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [1:0]       dest;
        logic [WIDTH-1:0] data;
        logic             last;
    } beat_t;

    beat_t      q[$];
    bit         m_inpkt = 1'b0;
    logic [1:0] m_lock  = 2'd0;
    int         n_delivered = 0;

    function automatic bit m_ready();
        return (q.size() == 0) || (out_ready[q[0].dest] == 1'b1);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        beat_t      nb;
        bit         acc;
        if (!rst_n) begin
            q.delete();
            m_inpkt = 1'b0;
            m_lock  = 2'd0;
        end else begin
            acc = in_valid && m_ready();
            if (q.size() != 0 && out_ready[q[0].dest]) begin
                void'(q.pop_front());
                n_delivered++;
            end
            if (acc) begin
                nb.dest = m_inpkt ? m_lock : in_sel;
                nb.data = in_data;
                nb.last = in_last;
                m_lock  = nb.dest;
                m_inpkt = !in_last;
                q.push_back(nb);
            end
        end
    end

    // Every cycle: DUT outputs against the model.
    always @(negedge clk) begin
        logic [3:0] eov;
        eov = 4'b0;
        if (q.size() > 1) chk("model_slot_depth", 32'(q.size()), 32'd1);
        if (q.size() != 0) eov = 4'b1 << q[0].dest;
        chk("out_valid", 32'(out_valid), 32'(eov));
        if (q.size() != 0) begin
            chk("out_data", 32'(out_data), 32'(q[0].data));
            chk("out_last", 32'(out_last), 32'(q[0].last));
        end
        chk("in_ready", 32'(in_ready), 32'(m_ready()));
        chk("busy", 32'(busy), 32'(m_inpkt));
        chk("cur_dest", 32'(cur_dest), 32'(m_lock));
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic setb(input logic v, input logic [WIDTH-1:0] d, input logic l, input logic [1:0] s);
        in_valid = v;
        in_data  = d;
        in_last  = l;
        in_sel   = s;
    endtask

    task automatic idle(input int n);
        setb(1'b0, '0, 1'b0, 2'd0);
        out_ready = 4'hF;
        repeat (n) step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]       sv_ov[4];
        logic [WIDTH-1:0] sv_d[4];
        int               total_beats;
        sv_ov = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        sv_d  = '{4'hA, 4'hB, 4'hC, 4'hD};

        rst_n = 1'b1;
        setb(1'b0, '0, 1'b0, 2'd0);
        out_ready = 4'h0;
        #3 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_out_last", 32'(out_last), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_cur_dest", 32'(cur_dest), 32'h0);
        repeat (2) step();
        rst_n = 1'b1;
        idle(2);

        // Single-beat packets to each destination, back to back.
        for (int i = 0; i < 4; i++) begin
            setb(1'b1, sv_d[i], 1'b1, 2'(i));
            @(negedge clk);
            chk("single_in_ready", 32'(in_ready), 32'h1);
            if (i > 0) begin
                chk("single_ov", 32'(out_valid), 32'(sv_ov[i-1]));
                chk("single_data", 32'(out_data), 32'(sv_d[i-1]));
            end
            step();
        end
        setb(1'b0, '0, 1'b0, 2'd0);
        @(negedge clk);
        chk("single_ov", 32'(out_valid), 32'h8);
        chk("single_data", 32'(out_data), 32'hD);
        idle(2);

        // Packet lock: later beats ignore in_sel.
        setb(1'b1, 4'h1, 1'b0, 2'd1);
        step();
        setb(1'b1, 4'h2, 1'b0, 2'd3);
        @(negedge clk);
        chk("lock_b0_ov", 32'(out_valid), 32'h2);
        chk("lock_b0_busy", 32'(busy), 32'h1);
        step();
        setb(1'b1, 4'h3, 1'b1, 2'd3);
        @(negedge clk);
        chk("lock_b1_ov", 32'(out_valid), 32'h2);
        chk("lock_b1_data", 32'(out_data), 32'h2);
        chk("lock_b1_busy", 32'(busy), 32'h1);
        step();
        setb(1'b0, '0, 1'b0, 2'd0);
        @(negedge clk);
        chk("lock_b2_ov", 32'(out_valid), 32'h2);
        chk("lock_b2_last", 32'(out_last), 32'h1);
        chk("lock_b2_busy", 32'(busy), 32'h0);
        chk("lock_cur_dest", 32'(cur_dest), 32'h1);
        idle(2);

        // Backpressure on dest 2, then drain and accept in the same edge.
        out_ready = 4'b1011;
        setb(1'b1, 4'h5, 1'b1, 2'd2);
        step();
        setb(1'b1, 4'h6, 1'b1, 2'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'h0);
            chk("bp_hold_data", 32'(out_data), 32'h5);
            chk("bp_hold_ov", 32'(out_valid), 32'h4);
            step();
        end
        out_ready = 4'hF;
        @(negedge clk);
        chk("bp_release_ready", 32'(in_ready), 32'h1);
        step();
        setb(1'b0, '0, 1'b0, 2'd0);
        @(negedge clk);
        chk("bp_next_ov", 32'(out_valid), 32'h1);
        chk("bp_next_data", 32'(out_data), 32'h6);
        idle(2);

        // Head-of-line: dest 0 stalled blocks a packet for dest 1.
        out_ready = 4'b1110;
        setb(1'b1, 4'h7, 1'b1, 2'd0);
        step();
        setb(1'b1, 4'h8, 1'b1, 2'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hol_ov", 32'(out_valid), 32'h1);
            chk("hol_in_ready", 32'(in_ready), 32'h0);
            step();
        end
        out_ready = 4'hF;
        step();
        setb(1'b0, '0, 1'b0, 2'd0);
        @(negedge clk);
        chk("hol_after_ov", 32'(out_valid), 32'h2);
        chk("hol_after_data", 32'(out_data), 32'h8);
        idle(2);

        // Reset mid-packet with a beat pending.
        out_ready = 4'h0;
        setb(1'b1, 4'hC, 1'b0, 2'd3);
        step();
        setb(1'b0, '0, 1'b0, 2'd0);
        @(negedge clk);
        chk("prerst_ov", 32'(out_valid), 32'h8);
        chk("prerst_busy", 32'(busy), 32'h1);
        step();
        rst_n = 1'b0;
        #1;
        chk("midrst_ov", 32'(out_valid), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_cur_dest", 32'(cur_dest), 32'h0);
        step();
        step();
        out_ready = 4'hF;
        setb(1'b1, 4'h9, 1'b1, 2'd2);
        rst_n = 1'b1;
        step();
        setb(1'b0, '0, 1'b0, 2'd0);
        @(negedge clk);
        chk("postrst_ov", 32'(out_valid), 32'h4);
        chk("postrst_data", 32'(out_data), 32'h9);
        idle(2);

        // Random packets with random readiness.
        total_beats = n_delivered;
        for (int p = 0; p < 100; p++) begin
            int len;
            len = $urandom_range(1, 8);
            for (int b = 0; b < len; b++) begin
                int tries;
                bit done;
                tries = 0;
                done  = 1'b0;
                while (!done) begin
                    for (int k = 0; k < 4; k++) out_ready[k] = ($urandom_range(0, 9) < 7);
                    setb(($urandom_range(0, 3) != 0), WIDTH'($urandom), (b == len - 1), 2'($urandom));
                    if (in_valid && m_ready()) done = 1'b1;
                    tries++;
                    if (!done && tries > 200) begin
                        chk("accept_timeout", 32'h1, 32'h0);
                        done = 1'b1;
                    end
                    step();
                end
                total_beats++;
            end
        end
        idle(4);
        chk("rand_delivered", 32'(n_delivered), 32'(total_beats));
        @(negedge clk);
        chk("rand_final_ov", 32'(out_valid), 32'h0);
        chk("rand_final_busy", 32'(busy), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
